crossing_ctrl: RTL
==================

CROSSING_CTRL -- requirements
Module: crossing_ctrl

Interface
REQ-001 The block SHALL have the following parameters, one per line: name, default, meaning.
- TICKS_PER_MS, 10: clklf cycles per millisecond (10 kHz clock).
- T_GREEN1, 8000: S1 green time in ms.
- T_MIN1, 2000: minimum S1 green time in ms when a request is pending.
- T_YELLOW1, 2000: S1 yellow time in ms.
- T_ALLRED, 1000: all-red clearance time in ms.
- T_GREEN2, 5000: S2 green time in ms.
- T_ACK, 5: maximum ms from a command pulse to the matching light feedback.
REQ-002 The block SHALL have the following ports, one per line: name, direction, width, meaning.
- clklf, in, 1: single clock, 10 kHz.
- reset, in, 1: asynchronous, active-low reset.
- en, in, 1: controller enable; asynchronous input.
- request, in, 1: crossing request button; asynchronous input, level.
- g1 / y1 / r1, in, 1 each: S1 light feedback, clklf domain.
- g2 / r2, in, 1 each: S2 light feedback, clklf domain.
- set1 / change1, out, 1 each: S1 commands, one-cycle pulses.
- set2 / change2, out, 1 each: S2 commands, one-cycle pulses.
- fault, out, 1: sticky fault flag.
- state_o, out, 4: current FSM state code, for debug.

Function
REQ-003 Command contract: a set pulse forces a light to red; a change pulse advances S1 green->yellow->red->green and S2 green->red->green.
REQ-004 en and request SHALL pass through a 2-flop synchronizer; all FSM decisions SHALL use the synchronized values.
REQ-005 A prescaler SHALL count 0..TICKS_PER_MS-1 and emit ms_tick on wrap; it SHALL restart at 0 on every state entry.
REQ-006 A 16-bit ms down-counter SHALL load the state's duration on entry, decrement on ms_tick, and expire when it reaches 0.
REQ-007 FSM states SHALL be: IDLE, INIT, S1_GO, S1_GREEN, S1_YELLOW, ALLRED1, S2_GO, S2_GREEN, ALLRED2, FAULT.
REQ-008 IDLE: no pulses are issued. The FSM moves to INIT when en_sync=1.
REQ-009 INIT: set1 and set2 pulse together in the entry cycle. The FSM moves to S1_GO when r1=1 and r2=1. If this has not happened within T_ACK ms, it moves to FAULT.
REQ-010 S1_GO: change1 pulses on entry. The FSM moves to S1_GREEN when g1=1, or to FAULT after T_ACK ms.
REQ-011 S1_GREEN: the timer loads T_GREEN1.
- If request_sync=1, the expiry point becomes min(remaining time, time to reach T_MIN1 elapsed).
- On expiry, change1 pulses and the FSM moves to S1_YELLOW.
- The request latch is cleared on entry to S2_GREEN.
REQ-012 S1_YELLOW: y1 SHALL be 1 within T_ACK ms, otherwise FAULT. After T_YELLOW1 ms, change1 pulses and the FSM moves to ALLRED1.
REQ-013 ALLRED1: r1 SHALL be 1 within T_ACK ms, otherwise FAULT. After T_ALLRED ms, the FSM moves to S2_GO.
REQ-014 S2_GO and S2_GREEN follow the same rules as S1_GO and S1_GREEN, using change2, g2 and T_GREEN2; S2 ignores request. Expiry moves to ALLRED2 with a change2 pulse.
REQ-015 ALLRED2: r2 SHALL be 1 within T_ACK ms, otherwise FAULT. After T_ALLRED ms, the FSM moves to S1_GO (wrap-around).
REQ-016 Conflict monitor: in any cycle where (g1|y1)=1 and g2=1, the FSM SHALL move to FAULT on the next edge, regardless of state.
REQ-017 FAULT:
- fault=1.
- set1 and set2 pulse once on entry; no further pulses.
- The state is left only by reset.
REQ-018 When en_sync falls in any state except FAULT, set1 and set2 pulse once and the FSM moves to IDLE.
REQ-019 Priority when events coincide: reset > conflict > ack timeout > en falling > timer expiry > request.
REQ-020 At most one pulse per port per cycle. Every pulse SHALL be exactly one clklf cycle long and registered (no combinational outputs).

Reset
REQ-021 While reset=0, the block SHALL hold:
- FSM = IDLE.
- All pulse outputs = 0, fault = 0, state_o = IDLE code.
- Prescaler, timer, synchronizers and request latch = 0.
REQ-022 A reset asserted mid-cycle SHALL take effect immediately, with no partial pulse. After release, the block SHALL wait for en_sync before issuing any pulse.

Structure
REQ-023 A shared package SHALL hold the state encoding constants and the default timing constants.
REQ-024 The ms prescaler plus down-counter SHALL be one sub-module, ms_timer (load, duration, expired, ms_tick).

Verification
All directed tests use TICKS_PER_MS=10, T_GREEN1=8, T_MIN1=3, T_YELLOW1=2, T_ALLRED=1, T_GREEN2=5, T_ACK=2, with an ideal semaforo model.
REQ-025 Nominal cycle:
- Stimulus: en=1.
- Expected: set1 and set2 pulse 3 cycles later. change1 marks S1 green 80 cycles, yellow 20, all-red 10. S2 green 50 cycles, then all-red 10, then S1_GO again.
REQ-026 Request during S1 green:
- Stimulus: request=1 at S1 green elapsed 1 ms.
- Expected: change1 at 3 ms elapsed (30 cycles), not 80.
REQ-027 Missing acknowledge:
- Stimulus: the model ignores change1.
- Expected: fault=1 exactly 20 cycles after the change1 pulse. set1 and set2 pulse once, then no pulses until reset.
REQ-028 Conflict:
- Stimulus: force g1=1 and g2=1 for 1 cycle during S2_GREEN.
- Expected: FAULT on the next edge, fault=1.
REQ-029 Reset mid-operation:
- Stimulus: reset=0 in S1_YELLOW, then released with en=1.
- Expected: all outputs 0 immediately; INIT pulses reappear 3 cycles after release.
REQ-030 Disable:
- Stimulus: en falls during ALLRED1.
- Expected: set1 and set2 pulse once and state_o = IDLE. No change pulses while en=0.

Source files
------------

// File: rtl/crossing_ctrl_pkg.sv
// Shared state encoding and default timing for the pedestrian crossing controller.
package crossing_ctrl_pkg;

  typedef enum logic [3:0] {
    ST_IDLE      = 4'd0,
    ST_INIT      = 4'd1,
    ST_S1_GO     = 4'd2,
    ST_S1_GREEN  = 4'd3,
    ST_S1_YELLOW = 4'd4,
    ST_ALLRED1   = 4'd5,
    ST_S2_GO     = 4'd6,
    ST_S2_GREEN  = 4'd7,
    ST_ALLRED2   = 4'd8,
    ST_FAULT     = 4'd9
  } state_t;

  localparam int DEF_TICKS_PER_MS = 10;
  localparam int DEF_T_GREEN1     = 8000;
  localparam int DEF_T_MIN1       = 2000;
  localparam int DEF_T_YELLOW1    = 2000;
  localparam int DEF_T_ALLRED     = 1000;
  localparam int DEF_T_GREEN2     = 5000;
  localparam int DEF_T_ACK        = 5;

  // True when `limit` ms have elapsed, or will have elapsed at this cycle's ms tick.
  function automatic logic ms_reached(input logic [15:0] elapsed, input logic tick,
                                      input logic [15:0] limit);
    return ({1'b0, elapsed} + {16'd0, tick}) >= {1'b0, limit};
  endfunction

endpackage

// File: rtl/crossing_ctrl_ms_timer.sv
// Millisecond prescaler plus 16-bit ms down-counter; both restart on load.
module ms_timer #(
  parameter int TICKS_PER_MS = 10
) (
  input  logic        clklf,
  input  logic        reset,
  input  logic        load,
  input  logic [15:0] duration,
  output logic        ms_tick,
  output logic        expired
);

  logic [15:0] presc;
  logic [15:0] remaining;

  assign ms_tick = (presc == 16'(TICKS_PER_MS - 1));
  // Expiry is flagged in the cycle whose tick brings the count to zero,
  // so the owner leaves the state exactly duration*TICKS_PER_MS cycles after entry.
  assign expired = (remaining == 16'd0) || (ms_tick && remaining == 16'd1);

  always_ff @(posedge clklf or negedge reset) begin
    if (!reset) begin
      presc     <= 16'd0;
      remaining <= 16'd0;
    end else if (load) begin
      presc     <= 16'd0;
      remaining <= duration;
    end else begin
      presc <= ms_tick ? 16'd0 : presc + 16'd1;
      if (ms_tick && remaining != 16'd0) remaining <= remaining - 16'd1;
    end
  end

endmodule

// File: rtl/crossing_ctrl.sv
// Two-signal crossing controller: sequences S1/S2 via set/change pulses,
// supervises light feedback and latches a sticky fault.
module crossing_ctrl
  import crossing_ctrl_pkg::*;
#(
  parameter int TICKS_PER_MS = DEF_TICKS_PER_MS,
  parameter int T_GREEN1     = DEF_T_GREEN1,
  parameter int T_MIN1       = DEF_T_MIN1,
  parameter int T_YELLOW1    = DEF_T_YELLOW1,
  parameter int T_ALLRED     = DEF_T_ALLRED,
  parameter int T_GREEN2     = DEF_T_GREEN2,
  parameter int T_ACK        = DEF_T_ACK
) (
  input  logic       clklf,
  input  logic       reset,
  input  logic       en,
  input  logic       request,
  input  logic       g1,
  input  logic       y1,
  input  logic       r1,
  input  logic       g2,
  input  logic       r2,
  output logic       set1,
  output logic       change1,
  output logic       set2,
  output logic       change2,
  output logic       fault,
  output logic [3:0] state_o
);

  state_t      state, nxt_state;
  logic        en_meta, en_sync, req_meta, request_sync, req_latch;
  logic        nxt_set1, nxt_change1, nxt_set2, nxt_change2;
  logic        load, ms_tick, expired;
  logic [15:0] duration, elapsed_ms;
  logic        ack_state, ack_now, ack_seen, ack_timeout;
  logic        conflict, req_pend, min_reached;

  assign state_o = state;

  always_ff @(posedge clklf or negedge reset) begin
    if (!reset) begin
      en_meta      <= 1'b0;
      en_sync      <= 1'b0;
      req_meta     <= 1'b0;
      request_sync <= 1'b0;
    end else begin
      en_meta      <= en;
      en_sync      <= en_meta;
      req_meta     <= request;
      request_sync <= req_meta;
    end
  end

  ms_timer #(.TICKS_PER_MS(TICKS_PER_MS)) u_ms_timer (
    .clklf   (clklf),
    .reset   (reset),
    .load    (load),
    .duration(duration),
    .ms_tick (ms_tick),
    .expired (expired)
  );

  // Feedback expected after the command issued on entry to each state.
  always_comb begin
    ack_state = 1'b1;
    ack_now   = 1'b0;
    case (state)
      ST_INIT:      ack_now = r1 & r2;
      ST_S1_GO:     ack_now = g1;
      ST_S1_YELLOW: ack_now = y1;
      ST_ALLRED1:   ack_now = r1;
      ST_S2_GO:     ack_now = g2;
      ST_ALLRED2:   ack_now = r2;
      default:      ack_state = 1'b0;
    endcase
  end

  assign ack_timeout = ack_state && !ack_seen && !ack_now &&
                       ms_reached(elapsed_ms, ms_tick, 16'(T_ACK));
  assign conflict    = (g1 | y1) & g2;
  assign req_pend    = req_latch | request_sync;
  assign min_reached = ms_reached(elapsed_ms, ms_tick, 16'(T_MIN1));

  always_comb begin
    nxt_state   = state;
    nxt_set1    = 1'b0;
    nxt_set2    = 1'b0;
    nxt_change1 = 1'b0;
    nxt_change2 = 1'b0;
    if (state == ST_FAULT) begin
      nxt_state = ST_FAULT;
    end else if (conflict || ack_timeout) begin
      nxt_state = ST_FAULT;
      nxt_set1  = 1'b1;
      nxt_set2  = 1'b1;
    end else if (state != ST_IDLE && !en_sync) begin
      nxt_state = ST_IDLE;
      nxt_set1  = 1'b1;
      nxt_set2  = 1'b1;
    end else begin
      case (state)
        ST_IDLE: if (en_sync) begin
          nxt_state = ST_INIT;
          nxt_set1  = 1'b1;
          nxt_set2  = 1'b1;
        end
        ST_INIT: if (ack_now) begin
          nxt_state   = ST_S1_GO;
          nxt_change1 = 1'b1;
        end
        ST_S1_GO:    if (ack_now) nxt_state = ST_S1_GREEN;
        ST_S1_GREEN: if (expired || (req_pend && min_reached)) begin
          nxt_state   = ST_S1_YELLOW;
          nxt_change1 = 1'b1;
        end
        ST_S1_YELLOW: if (expired) begin
          nxt_state   = ST_ALLRED1;
          nxt_change1 = 1'b1;
        end
        ST_ALLRED1: if (expired) begin
          nxt_state   = ST_S2_GO;
          nxt_change2 = 1'b1;
        end
        ST_S2_GO:    if (ack_now) nxt_state = ST_S2_GREEN;
        ST_S2_GREEN: if (expired) begin
          nxt_state   = ST_ALLRED2;
          nxt_change2 = 1'b1;
        end
        ST_ALLRED2: if (expired) begin
          nxt_state   = ST_S1_GO;
          nxt_change1 = 1'b1;
        end
        default: nxt_state = ST_FAULT;
      endcase
    end
  end

  // Every transition is a change of state, so entry is simply "next differs".
  assign load = (nxt_state != state);

  always_comb begin
    duration = 16'd0;
    case (nxt_state)
      ST_INIT, ST_S1_GO, ST_S2_GO: duration = 16'(T_ACK);
      ST_S1_GREEN:                 duration = 16'(T_GREEN1);
      ST_S1_YELLOW:                duration = 16'(T_YELLOW1);
      ST_ALLRED1, ST_ALLRED2:      duration = 16'(T_ALLRED);
      ST_S2_GREEN:                 duration = 16'(T_GREEN2);
      default:                     duration = 16'd0;
    endcase
  end

  always_ff @(posedge clklf or negedge reset) begin
    if (!reset) begin
      state      <= ST_IDLE;
      set1       <= 1'b0;
      set2       <= 1'b0;
      change1    <= 1'b0;
      change2    <= 1'b0;
      fault      <= 1'b0;
      elapsed_ms <= 16'd0;
      ack_seen   <= 1'b0;
      req_latch  <= 1'b0;
    end else begin
      state   <= nxt_state;
      set1    <= nxt_set1;
      set2    <= nxt_set2;
      change1 <= nxt_change1;
      change2 <= nxt_change2;
      fault   <= (nxt_state == ST_FAULT);
      if (load) begin
        elapsed_ms <= 16'd0;
        ack_seen   <= 1'b0;
      end else begin
        if (ms_tick && elapsed_ms != 16'hFFFF) elapsed_ms <= elapsed_ms + 16'd1;
        if (ack_now) ack_seen <= 1'b1;
      end
      if (load && nxt_state == ST_S2_GREEN) req_latch <= 1'b0;
      else if (request_sync)                req_latch <= 1'b1;
    end
  end

endmodule
